instruction_buffer: RTL
=======================

INSTRUCTION_BUFFER -- requirements
Module: instruction_buffer

Interface
REQ-001 Parameter N, default 32: instruction word width in bits, at least 8.
REQ-002 Parameter DEPTH, default 4: number of buffered instruction words; a power of 2, at least 2.
REQ-003 Port clock  input  1: positive-edge clock, the only clock.
REQ-004 Port R  input  1: reset, synchronous and active-high.
REQ-005 Port D  input  N: incoming instruction word from fetch.
REQ-006 Port in_valid  input  1: D is valid this cycle.
REQ-007 Port in_ready  output  1: buffer accepts D this cycle.
REQ-008 Port flush  input  1: synchronous discard of all buffered words (branch redirect).
REQ-009 Port Q  output  N: current instruction at the head of the buffer.
REQ-010 Port out_valid  output  1: Q holds a valid instruction.
REQ-011 Port out_ready  input  1: decode consumes Q this cycle.
REQ-012 Port count  output  $clog2(DEPTH+1): number of words held.

Function
REQ-013 Push occurs on a rising clock edge when in_valid and in_ready are both 1; pop occurs when out_valid and out_ready are both 1.
REQ-014 Storage is a circular FIFO with write and read pointers of $clog2(DEPTH) bits; both wrap from DEPTH-1 to 0.
REQ-015 in_ready = (count < DEPTH) and not R and not flush; a pop in the same cycle does not raise in_ready when full.
REQ-016 out_valid = (count != 0); Q = head word when out_valid is 1, otherwise all zeros.
REQ-017 Without bypass, a word pushed at edge k is visible on Q with out_valid=1 after edge k; latency is one cycle.
REQ-018 Simultaneous push and pop: count is unchanged, and both pointers advance.
REQ-019 Push only increments count by 1; pop only decrements it by 1; count never exceeds DEPTH and never underflows.
REQ-020 Word order is strictly preserved: first in, first out.
REQ-021 flush=1 at an edge sets count and both pointers to 0; flush has priority over push and pop; a word offered in that cycle is dropped.
REQ-022 Words that are already stored and not pointed to are not cleared by flush; only the pointers and count are reset.

Reset
REQ-023 R=1 at an edge clears count, write pointer and read pointer to 0; it has priority over flush, push and pop.
REQ-024 While R=1: in_ready=0; after the first edge, out_valid=0 and Q=0.
REQ-025 Reset asserted mid-operation discards all contents; in_ready returns to 1 in the first cycle after R falls.

Configuration
REQ-026 Macro INSTRUCTION_BUFFER_BYPASS_EN compiles in a combinational bypass from D to Q.
REQ-027 With the macro, when count=0, in_valid=1 and in_ready=1:
- out_valid=1 and Q=D in the same cycle.
- If out_ready=1, the word is consumed and not stored, and count stays 0.
- If out_ready=0, the word is stored normally.
REQ-028 Without the macro, the one-cycle latency of REQ-017 applies, and no combinational path from D or in_valid to Q or out_valid exists.

Structure
REQ-029 Shared package instruction_buffer_pkg holds:
- default constants IB_N=32 and IB_DEPTH=4;
- a pointer-width function (clog2).
REQ-030 One sub-module, ib_storage, implements the DEPTH x N register array: one write port, one asynchronous read port, no reset on the data array.
REQ-031 Pointer, count, handshake and bypass logic reside in instruction_buffer.

Verification (N=32, DEPTH=4)
REQ-032 Reset then idle -> count=0, out_valid=0, Q=0, in_ready=1; while R=1, in_ready=0.
REQ-033 Push 0x11111111, 0x22222222, 0x33333333 and 0x44444444 with out_ready=0 -> count=4, in_ready=0, and Q=0x11111111 throughout; a 5th push of 0x55555555 is ignored.
REQ-034 From full, pop 4 times with in_valid=0 -> Q sequence 0x11111111, 0x22222222, 0x33333333, 0x44444444, then out_valid=0, Q=0, and count=0.
REQ-035 Continuous push and pop at count=2 for 8 cycles -> count stays 2 and order is preserved across pointer wrap.
REQ-036 count=3 with flush=1 and in_valid=1 (D=0xDEADBEEF) -> next cycle count=0, out_valid=0, and 0xDEADBEEF is never output.
REQ-037 Empty buffer, in_valid=1 with D=0xCAFEF00D and out_ready=1:
- with the bypass macro: Q=0xCAFEF00D and out_valid=1 in the same cycle, then count=0;
- without the macro: the word appears on Q one cycle later.

Source files
------------

// File: rtl/instruction_buffer_pkg.sv
// Shared constants and helpers for the instruction buffer.
package instruction_buffer_pkg;

  localparam int IB_N     = 32;
  localparam int IB_DEPTH = 4;

  // Pointer width for a power-of-2 depth; never narrower than one bit.
  function automatic int ptr_width(input int depth);
    int w;
    w = 0;
    while ((1 << w) < depth) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ib_storage.sv
// DEPTH x N register array: one synchronous write port, one asynchronous read port.
module ib_storage
  import instruction_buffer_pkg::*;
#(
  parameter int N     = IB_N,
  parameter int DEPTH = IB_DEPTH,
  parameter int PW    = ptr_width(IB_DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [PW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] mem [DEPTH];

  // NOTE: the data array has no reset; validity is tracked by the pointers
  // and count, so clearing the words would only cost a reset fan-out.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_buffer.sv
// Circular FIFO between fetch and decode with flush for branch redirects.
// Define INSTRUCTION_BUFFER_BYPASS_EN to add a same-cycle D->Q path when empty.
module instruction_buffer
  import instruction_buffer_pkg::*;
#(
  parameter int N     = IB_N,
  parameter int DEPTH = IB_DEPTH
) (
  input  logic                       clock,
  input  logic                       R,
  input  logic [N-1:0]               D,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [N-1:0]               Q,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [N-1:0]  head;
  logic          empty;
  logic          push;
  logic          pop;
  logic          store_push;
  logic          store_pop;

  assign empty    = (count == '0);
  assign in_ready = (count < CW'(DEPTH)) && !R && !flush;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

`ifdef INSTRUCTION_BUFFER_BYPASS_EN
  logic bypass;

  // An offered word goes straight to decode when nothing is queued ahead of it.
  assign bypass     = empty && push;
  assign out_valid  = !empty || bypass;
  assign store_push = push && !(bypass && out_ready);
  assign store_pop  = pop && !empty;

  always_comb begin
    Q = '0;
    if (!empty)      Q = head;
    else if (bypass) Q = D;
  end
`else
  assign out_valid  = !empty;
  assign store_push = push;
  assign store_pop  = pop;
  assign Q          = out_valid ? head : '0;
`endif

  ib_storage #(
    .N     (N),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_storage (
    .clock (clock),
    .we    (store_push),
    .waddr (wr_ptr),
    .wdata (D),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (R || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of 2.
      if (store_push) wr_ptr <= wr_ptr + 1'b1;
      if (store_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({store_push, store_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
